// File: rtl/bit_stuff_tx_pkg.sv
// Shared constants and types for the bit-stuffing link framer (tx side and
// the matching receive-side destuffer/flag detector).
package bit_stuff_tx_pkg;

  localparam logic [7:0]  FLAG            = 8'h7E;
  localparam int unsigned RUN_LEN_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    FLAG_PRE,
    DATA,
    STUFF,
    FLAG_POST
  } state_e;

endpackage

// File: rtl/bit_stuff_tx_if.sv
// Byte-source handshake and serial line signals of the bit-stuffing framer.
interface bit_stuff_tx_if;

  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sof;
  logic       eof;
  logic       tx_bit;
  logic       tx_en;
  logic       busy;
  logic       underrun;

  modport master (
    output din, din_valid, sof, eof,
    input  din_ready, tx_bit, tx_en, busy, underrun
  );

  modport slave (
    input  din, din_valid, sof, eof,
    output din_ready, tx_bit, tx_en, busy, underrun
  );

endinterface

// File: rtl/bit_stuff_ctr.sv
// Consecutive-ones counter; stuff_req_o flags the data 1 that completes a run
// of RUN_LEN, so the next line bit must be a stuffed 0.
module bit_stuff_ctr
  import bit_stuff_tx_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic stuff_req_o
);

  localparam logic [2:0] LAST = 3'(RUN_LEN - 1);

  logic [2:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (clr_i) begin
      ones_d = '0;
    end else if (inc_i) begin
      ones_d = ones_q + 3'd1;
    end
  end

  assign stuff_req_o = inc_i && (ones_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/bit_stuff_tx.sv
// Transmit framer: flag-wrapped, LSB-first serializer with zero insertion
// after RUN_LEN consecutive data ones.
module bit_stuff_tx
  import bit_stuff_tx_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  bit_stuff_tx_if.slave  bus
);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       eof_l_q, eof_l_d;

  logic clr, inc, stuff_req, done;
  logic tx_bit, tx_en, din_ready, underrun;

  bit_stuff_ctr #(.RUN_LEN(RUN_LEN)) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .inc_i       (inc),
    .stuff_req_o (stuff_req)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    eof_l_d   = eof_l_q;
    tx_bit    = 1'b0;
    tx_en     = 1'b1;
    din_ready = 1'b0;
    underrun  = 1'b0;
    clr       = 1'b0;
    inc       = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_en     = 1'b0;
        din_ready = 1'b1;
        if (bus.din_valid) begin
          shift_d   = bus.din;
          eof_l_d   = bus.eof;
          clr       = 1'b1;
          bit_cnt_d = '0;
          state_d   = bus.sof ? FLAG_PRE : DATA;
        end
      end
      FLAG_PRE, FLAG_POST: begin
        tx_bit    = FLAG[bit_cnt_q];
        clr       = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = (state_q == FLAG_PRE) ? DATA : IDLE;
        end
      end
      DATA: begin
        tx_bit    = shift_q[bit_cnt_q];
        inc       = tx_bit;
        clr       = !tx_bit;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (stuff_req) begin
          state_d = STUFF;
        end else if (bit_cnt_q == 3'd7) begin
          done = 1'b1;
        end
      end
      STUFF: begin
        clr = 1'b1;
        // bit_cnt already advanced past the stuffed bit; 0 means it followed bit 7
        if (bit_cnt_q == 3'd0) begin
          done = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      bit_cnt_d = '0;
      if (eof_l_q) begin
        state_d = FLAG_POST;
      end else begin
        din_ready = 1'b1;
        if (bus.din_valid) begin
          shift_d = bus.din;
          eof_l_d = bus.eof;
          state_d = DATA;
        end else begin
          underrun = 1'b1;
          state_d  = FLAG_POST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      eof_l_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      eof_l_q   <= eof_l_d;
    end
  end

  assign bus.tx_bit    = tx_bit;
  assign bus.tx_en     = tx_en;
  assign bus.din_ready = din_ready;
  assign bus.underrun  = underrun;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_stuff_tx.sv
// Directed bench for bit_stuff_tx (RUN_LEN=5): captures each frame's line
// bits as a '0'/'1' string and compares with hand-derived sequences.
module tb_bit_stuff_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit_stuff_tx_if bus ();

  bit_stuff_tx #(.RUN_LEN(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_pass = 0;
  int    n_chk  = 0;
  string F      = "01111110";

  string fr_bits;
  int    fr_under;
  int    fr_under_idx;
  int    fr_rdy;
  int    n_en;

  task automatic chk_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_str(input string tag, input string got, input string exp);
    n_chk++;
    assert (got == exp) n_pass++;
    else $error("FAIL %s: observed %s expected %s", tag, got, exp);
  endtask

  function automatic int runs6(input string s);
    int run = 0;
    int n   = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h31) begin
        run++;
        if (run == 6) n++;
      end else begin
        run = 0;
      end
    end
    return n;
  endfunction

  // Feed up to two bytes, record every tx_en cycle until the line goes idle.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input int nb, input logic sof, input logic eof_last);
    int   idx = 0;
    logic acc;
    bit   started = 0;
    fr_bits      = "";
    fr_under     = 0;
    fr_under_idx = -1;
    fr_rdy       = 0;
    bus.din       = b0;
    bus.din_valid = 1'b1;
    bus.sof       = sof;
    bus.eof       = (nb == 1) ? eof_last : 1'b0;
    #1;
    acc = bus.din_valid && bus.din_ready;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < nb) begin
          bus.din = b1;
          bus.sof = 1'b0;
          bus.eof = (idx == nb - 1) ? eof_last : 1'b0;
        end else begin
          bus.din_valid = 1'b0;
          bus.sof       = 1'b0;
          bus.eof       = 1'b0;
        end
      end
      #1;
      if (bus.tx_en) begin
        started = 1;
        if (bus.tx_bit) fr_bits = {fr_bits, "1"};
        else            fr_bits = {fr_bits, "0"};
        if (bus.din_ready) fr_rdy++;
        if (bus.underrun) begin
          fr_under++;
          fr_under_idx = fr_bits.len() - 1;
        end
      end else if (started) begin
        break;
      end
      acc = bus.din_valid && bus.din_ready;
    end
  endtask

  initial begin
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.eof       = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk_int("rst_tx_en",     int'(bus.tx_en),     0);
    chk_int("rst_tx_bit",    int'(bus.tx_bit),    0);
    chk_int("rst_busy",      int'(bus.busy),      0);
    chk_int("rst_underrun",  int'(bus.underrun),  0);
    chk_int("rst_din_ready", int'(bus.din_ready), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;

    // 1: all-zero byte, no stuffing
    run_frame(8'h00, 8'h00, 1, 1'b1, 1'b1);
    chk_str("t1_line",  fr_bits, {F, "00000000", F});
    chk_int("t1_len",   fr_bits.len(), 24);
    chk_int("t1_rdy",   fr_rdy, 0);
    chk_int("t1_under", fr_under, 0);
    chk_int("t1_flags", runs6(fr_bits), 2);
    chk_int("t1_busy",  int'(bus.busy), 0);

    // 2: all-ones byte, stuff after 5th one
    run_frame(8'hFF, 8'h00, 1, 1'b1, 1'b1);
    chk_str("t2_line",  fr_bits, {F, "111110111", F});
    chk_int("t2_len",   fr_bits.len(), 25);
    chk_int("t2_flags", runs6(fr_bits), 2);
    chk_int("t2_under", fr_under, 0);

    // 3: back-to-back, stuff mid-byte and after bit 7
    run_frame(8'h1F, 8'hF8, 2, 1'b1, 1'b1);
    chk_str("t3_line",  fr_bits, {F, "111110000", "000111110", F});
    chk_int("t3_len",   fr_bits.len(), 34);
    chk_int("t3_rdy",   fr_rdy, 1);
    chk_int("t3_under", fr_under, 0);
    chk_int("t3_flags", runs6(fr_bits), 2);

    // 4: run of ones spanning a byte boundary
    run_frame(8'hE0, 8'h03, 2, 1'b1, 1'b1);
    chk_str("t4_line", fr_bits, {F, "00000111", "110000000", F});
    chk_int("t4_len",  fr_bits.len(), 33);
    chk_int("t4_rdy",  fr_rdy, 1);

    // 5: source starves after first byte
    run_frame(8'hA5, 8'h00, 1, 1'b1, 1'b0);
    chk_str("t5_line",      fr_bits, {F, "10100101", F});
    chk_int("t5_under",     fr_under, 1);
    chk_int("t5_under_idx", fr_under_idx, 15);
    chk_int("t5_rdy",       fr_rdy, 1);
    chk_int("t5_busy",      int'(bus.busy), 0);
    chk_int("t5_idle_rdy",  int'(bus.din_ready), 1);

    // 6: reset after 3 data bits of an all-ones byte
    bus.din       = 8'hFF;
    bus.din_valid = 1'b1;
    bus.sof       = 1'b1;
    bus.eof       = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.eof       = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chk_int("t6_pre_en",  int'(bus.tx_en), 1);
    chk_int("t6_pre_bit", int'(bus.tx_bit), 1);
    rst = 1'b0;
    #1;
    chk_int("t6_rst_en",    int'(bus.tx_en),     0);
    chk_int("t6_rst_bit",   int'(bus.tx_bit),    0);
    chk_int("t6_rst_busy",  int'(bus.busy),      0);
    chk_int("t6_rst_rdy",   int'(bus.din_ready), 1);
    chk_int("t6_rst_under", int'(bus.underrun),  0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    n_en = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (bus.tx_en) n_en++;
    end
    chk_int("t6_no_postflag", n_en, 0);
    run_frame(8'hFF, 8'h00, 1, 1'b1, 1'b1);
    chk_str("t6_line", fr_bits, {F, "111110111", F});
    chk_int("t6_busy", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bit_stuff_tx.md
Name: bit_stuff_tx

Overview:
Transmit-side framer for the serial link whose receive path uses a six-consecutive-ones detector.
- Accepts bytes over a valid/ready handshake and serializes them LSB first.
- Wraps each frame in flag bytes 8'b0111_1110.
- Inserts a 0 after every RUN_LEN consecutive data 1s, so six consecutive 1s on the line occur only inside a flag.
- Sits between the byte source and the line driver.

Parameters:
RUN_LEN, 5, number of consecutive data 1s after which one stuffed 0 is emitted. Legal range 2..7.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
din  in  8  data byte
din_valid  in  1  din holds a valid byte
din_ready  out  1  byte accepted on clk edge when din_valid && din_ready
sof  in  1  sampled with accepted byte; frame starts with a pre-flag
eof  in  1  sampled with accepted byte; frame closes after this byte
tx_bit  out  1  serial line bit
tx_en  out  1  tx_bit is a frame bit this cycle
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse: source starved mid-frame

Behaviour:
- States: IDLE, FLAG_PRE, DATA, STUFF, FLAG_POST.
- Moore outputs: tx_bit, tx_en and busy decode from the state, bit_cnt[2:0] and the byte shift register. Each line bit lasts exactly one cycle.
- Reset (rst low, any time including mid-frame) forces:
  - state=IDLE, bit_cnt=0, ones_cnt=0, eof_l=0;
  - tx_en=0, tx_bit=0, busy=0, underrun=0, din_ready=1.
  - A partially sent frame is abandoned and no post-flag is sent.
- IDLE:
  - tx_en=0, tx_bit=0, din_ready=1.
  - On accept: latch din, set eof_l=eof, ones_cnt=0.
  - Next state is FLAG_PRE if sof=1, else DATA, at bit_cnt=0.
- FLAG_PRE / FLAG_POST:
  - Emit flag bit[bit_cnt] (sequence 0,1,1,1,1,1,1,0) over 8 cycles, tx_en=1.
  - No stuffing; ones_cnt held at 0.
  - FLAG_PRE goes to DATA at bit_cnt=0. FLAG_POST goes to IDLE, so there is at least one IDLE cycle between frames.
- DATA:
  - Emit shift[bit_cnt], tx_en=1.
  - Bit 1: ones_cnt+1. Bit 0: ones_cnt=0.
  - If this bit is 1 and ones_cnt==RUN_LEN-1, next state is STUFF; bit_cnt still advances.
- STUFF: emit 0, tx_en=1, ones_cnt=0, then resume.
- Byte completion = the last obligation of the byte: DATA at bit_cnt=7 with no stuff pending, or the STUFF that follows bit 7.
  - ones_cnt carries across byte boundaries within a frame.
- At the completion cycle:
  - eof_l=1: din_ready=0, next state FLAG_POST.
  - eof_l=0: din_ready=1.
    - If din_valid: accept, go to DATA at bit_cnt=0 with no gap. eof is re-latched; sof is ignored mid-frame.
    - If !din_valid: underrun=1 for this cycle, next state FLAG_POST.
- din_ready=0 in every other non-IDLE cycle.
- Line property for RUN_LEN=5: the receive-side six-ones detector fires exactly once per flag (on its 6th 1) and never inside data.
- Frame length = 8·sof + 8·bytes + stuffs + 8 cycles.

Decomposition:
- Shared package:
  - FLAG = 8'h7E;
  - state enum (IDLE, FLAG_PRE, DATA, STUFF, FLAG_POST);
  - RUN_LEN default constant, shared with the receive-side destuffer and detector.
- One natural sub-module: bit_stuff_ctr, the ones counter with a stuff_req output, clear/inc inputs and RUN_LEN parameter. Everything else stays in the top FSM.

Test Plan:
1. Reset, then din=8'h00, sof=1, eof=1 → 24 tx_en cycles: 01111110, 00000000, 01111110. din_ready low from the cycle after accept until back in IDLE; no underrun.
2. din=8'hFF, sof=1, eof=1 → data segment 1,1,1,1,1,0,1,1,1 (9 cycles), 25 total. Line carries six consecutive 1s only within the two flags.
3. Back-to-back 8'h1F (sof), then 8'hF8 (eof), din_valid held → 34 cycles: flag, 11111 0 000, 00011111 0, flag. din_ready pulses exactly once in a frame cycle; no idle gap.
4. Cross-byte run: 8'hE0 (sof), then 8'h03 (eof) → ones 3+2: stuffed 0 after bit1 of the second byte; data segment 17 bits.
5. Underrun: 8'hA5, sof=1, eof=0, din_valid then low → underrun=1 for one cycle at byte completion; post-flag follows; busy falls; next accept only from IDLE.
6. Reset mid-DATA (after 3 data bits), then a new frame with 8'hFF → tx_en=0 immediately while rst low, no post-flag. New frame stuffs after its 5th 1, confirming ones_cnt was cleared.
